laser_cover_scorer: RTL and testbench

Downstream checker for the two-laser placement engine. It snoops the same 40-point X/Y load stream the placement engine receives and keeps its own occupancy bitmap. When the engine pulses DONE, it captures C1/C2 and scans all 256 grid cells. It then reports how many distinct occupied cells the two radius-4 circles cover, so the system can score or self-check each result without stalling the next image load.

---
 rtl/laser_cover_scorer.sv | 158 +++++++++++++++
 tb/tb_laser_cover_scorer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/laser_cover_scorer.sv
// Checker that shadows the placement engine's point stream. It scans a snapshot
// bitmap after each DONE_IN and reports how many points the two radius-4 circles cover.
module laser_cover_scorer #(
    parameter int NPTS = 40
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    input  logic       DONE_IN,
    output logic [6:0] SCORE,
    output logic       SCORE_VALID,
    output logic       BUSY,
    output logic       OVERRUN
);

    localparam logic [6:0] LAST_SAMPLE = 7'(NPTS - 1);

    typedef enum logic {LD_LOAD, LD_WAIT} ld_state_t;
    typedef enum logic [1:0] {SC_IDLE, SC_SCAN, SC_REPORT} sc_state_t;

    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Squared distance is widened to 9 bits so 15^2 + 15^2 cannot wrap.
    function automatic logic in_circle(input logic [3:0] x, input logic [3:0] y,
                                       input logic [3:0] cx, input logic [3:0] cy);
        logic [8:0] dx;
        logic [8:0] dy;
        logic [8:0] d2;
        dx = {5'b0, abs_diff(x, cx)};
        dy = {5'b0, abs_diff(y, cy)};
        d2 = dx * dx + dy * dy;
        return d2 <= 9'd16;
    endfunction

    ld_state_t    ld_state_q, ld_state_d;
    sc_state_t    sc_state_q, sc_state_d;
    logic [6:0]   cnt_q, cnt_d;
    logic [255:0] loadmap_q, loadmap_d;
    logic [255:0] scanmap_q, scanmap_d;
    logic [3:0]   c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
    logic [7:0]   idx_q, idx_d;
    logic [6:0]   acc_q, acc_d;
    logic [6:0]   score_q, score_d;
    logic         score_valid_q, score_valid_d;
    logic         overrun_q, overrun_d;
    logic         hit;

    always_comb begin
        ld_state_d    = ld_state_q;
        sc_state_d    = sc_state_q;
        cnt_d         = cnt_q;
        loadmap_d     = loadmap_q;
        scanmap_d     = scanmap_q;
        c1x_d         = c1x_q;
        c1y_d         = c1y_q;
        c2x_d         = c2x_q;
        c2y_d         = c2y_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        score_d       = score_q;
        score_valid_d = 1'b0;
        overrun_d     = DONE_IN && (sc_state_q != SC_IDLE);

        hit = scanmap_q[idx_q] &
              (in_circle(idx_q[3:0], idx_q[7:4], c1x_q, c1y_q) |
               in_circle(idx_q[3:0], idx_q[7:4], c2x_q, c2y_q));

        // Loader: the DONE_IN cycle itself is not a sample; the next cycle is sample 0.
        if (DONE_IN) begin
            scanmap_d  = loadmap_q;
            loadmap_d  = '0;
            cnt_d      = '0;
            ld_state_d = LD_LOAD;
            c1x_d      = C1X;
            c1y_d      = C1Y;
            c2x_d      = C2X;
            c2y_d      = C2Y;
        end else if (ld_state_q == LD_LOAD) begin
            loadmap_d[{Y, X}] = 1'b1;
            cnt_d             = cnt_q + 7'd1;
            if (cnt_q == LAST_SAMPLE) begin
                ld_state_d = LD_WAIT;
            end
        end

        case (sc_state_q)
            SC_SCAN: begin
                acc_d = acc_q + {6'b0, hit};
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    sc_state_d = SC_REPORT;
                end
            end
            SC_REPORT: begin
                score_d       = acc_q;
                score_valid_d = 1'b1;
                sc_state_d    = SC_IDLE;
            end
            default: ;
        endcase

        // A new DONE_IN always wins: any scan or pending report is dropped.
        if (DONE_IN) begin
            sc_state_d    = SC_SCAN;
            idx_d         = '0;
            acc_d         = '0;
            score_d       = score_q;
            score_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ld_state_q    <= LD_LOAD;
            sc_state_q    <= SC_IDLE;
            cnt_q         <= '0;
            loadmap_q     <= '0;
            scanmap_q     <= '0;
            c1x_q         <= '0;
            c1y_q         <= '0;
            c2x_q         <= '0;
            c2y_q         <= '0;
            idx_q         <= '0;
            acc_q         <= '0;
            score_q       <= '0;
            score_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            ld_state_q    <= ld_state_d;
            sc_state_q    <= sc_state_d;
            cnt_q         <= cnt_d;
            loadmap_q     <= loadmap_d;
            scanmap_q     <= scanmap_d;
            c1x_q         <= c1x_d;
            c1y_q         <= c1y_d;
            c2x_q         <= c2x_d;
            c2y_q         <= c2y_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            score_q       <= score_d;
            score_valid_q <= score_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign SCORE       = score_q;
    assign SCORE_VALID = score_valid_q;
    assign BUSY        = (sc_state_q != SC_IDLE);
    assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_laser_cover_scorer.sv
// Scoreboard bench for laser_cover_scorer: directed images with hand-derived scores,
// a monitor pops expected SCORE/latency whenever SCORE_VALID is seen.
module tb_laser_cover_scorer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] X = '0, Y = '0;
    logic [3:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
    logic       DONE_IN = 1'b0;
    logic [6:0] SCORE;
    logic       SCORE_VALID;
    logic       BUSY;
    logic       OVERRUN;

    laser_cover_scorer #(.NPTS(40)) dut (
        .CLK(CLK), .RST(RST), .X(X), .Y(Y),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .DONE_IN(DONE_IN), .SCORE(SCORE), .SCORE_VALID(SCORE_VALID),
        .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int score;
        int cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ovr_count = 0;
    int         ovr_cyc = -1;
    logic [3:0] fx[40], fy[40], bx[40], by[40];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (OVERRUN) begin
            ovr_count++;
            ovr_cyc = cyc;
        end
        if (SCORE_VALID) begin
            if (sb.size() == 0) begin
                check("unexpected_score_valid", 1, 0);
            end else begin
                cur = sb.pop_front();
                check("score", int'(SCORE), cur.score);
                check("latency_cycle", cyc, cur.cyc);
                check("busy_at_report", int'(BUSY), 0);
            end
        end
    end

    task automatic load_img(input int which);
        for (int i = 0; i < 40; i++) begin
            X = (which == 1) ? bx[i] : fx[i];
            Y = (which == 1) ? by[i] : fy[i];
            @(posedge CLK); #1;
        end
    endtask

    // DONE_IN sampled at the next edge k; the report lands at edge k+257.
    task automatic pulse_done(input logic [3:0] c1x, input logic [3:0] c1y,
                              input logic [3:0] c2x, input logic [3:0] c2y,
                              input int exp_score, input int exp_ovr);
        C1X = c1x; C1Y = c1y; C2X = c2x; C2Y = c2y;
        DONE_IN = 1'b1;
        if (exp_score >= 0) sb.push_back('{exp_score, cyc + 258});
        @(posedge CLK); #1;
        DONE_IN = 1'b0;
        check("busy_after_done", int'(BUSY), 1);
        check("overrun_at_done", int'(OVERRUN), exp_ovr);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(posedge CLK); #1;
            t++;
        end
        if (sb.size() != 0) begin
            check("scan_timeout_pending", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        int n;
        int k1, k2, k3;
        n = 0;
        for (int dy = -4; dy <= 4; dy++) begin
            for (int dx = -4; dx <= 4; dx++) begin
                if (dx * dx + dy * dy <= 16 && n < 40) begin
                    fx[n] = 4'(8 + dx);
                    fy[n] = 4'(8 + dy);
                    n++;
                end
            end
        end
        for (int i = 0; i < 40; i++) begin
            bx[i] = 4'd0;
            by[i] = 4'd0;
        end
        bx[0] = 4'd8;  by[0] = 4'd12;
        bx[1] = 4'd12; by[1] = 4'd8;
        bx[2] = 4'd10; by[2] = 4'd11;
        bx[3] = 4'd11; by[3] = 4'd11;

        // Reset state
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_score", int'(SCORE), 0);
        check("reset_score_valid", int'(SCORE_VALID), 0);
        check("reset_busy", int'(BUSY), 0);
        check("reset_overrun", int'(OVERRUN), 0);
        RST = 1'b0;
        load_img(0);
        check("idle_busy", int'(BUSY), 0);

        // Full cover, both circles at (8,8); boundary image loads behind it
        pulse_done(4'd8, 4'd8, 4'd8, 4'd8, 40, 0);
        load_img(1);
        wait_drain();

        // Boundary/dedupe: (11,11) is outside, 36x(0,0) counts once
        pulse_done(4'd8, 4'd8, 4'd0, 4'd0, 4, 0);
        load_img(0);
        wait_drain();

        // Overlapping circles must not double count
        pulse_done(4'd8, 4'd8, 4'd9, 4'd8, 40, 0);
        load_img(0);
        wait_drain();

        // Overrun: second DONE_IN 100 cycles after the first
        ovr_count = 0;
        pulse_done(4'd8, 4'd8, 4'd8, 4'd8, -1, 0);
        k1 = cyc;
        load_img(1);
        while (cyc < k1 + 99) begin
            @(posedge CLK); #1;
        end
        pulse_done(4'd8, 4'd8, 4'd0, 4'd0, 4, 1);
        k2 = cyc;
        check("overrun_spacing", k2 - k1, 100);
        load_img(0);
        wait_drain();
        check("overrun_count", ovr_count, 1);
        check("overrun_cycle", ovr_cyc, k2);

        // Reset 50 cycles into a scan
        pulse_done(4'd8, 4'd8, 4'd8, 4'd8, -1, 0);
        k3 = cyc;
        load_img(1);
        while (cyc < k3 + 50) begin
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("midscan_reset_score", int'(SCORE), 0);
        check("midscan_reset_busy", int'(BUSY), 0);
        check("midscan_reset_valid", int'(SCORE_VALID), 0);
        RST = 1'b0;
        load_img(0);
        repeat (300) begin
            @(posedge CLK); #1;
        end
        pulse_done(4'd8, 4'd8, 4'd9, 4'd8, 40, 0);
        load_img(1);
        wait_drain();
        repeat (10) begin
            @(posedge CLK); #1;
        end
        check("final_overrun_count", ovr_count, 1);
        check("final_busy", int'(BUSY), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
